// File: rtl/phase_index_cordic.sv
// phase_index_cordic: vectoring-mode CORDIC turning a complex sample into a sine-table phase index and gain-scaled magnitude
module phase_index_cordic #(
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 8,
  parameter int ITER    = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PHASE_W-1:0]       out_phase,
  output logic [DATA_W:0]          out_mag
);
  localparam int XW = DATA_W + 3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic signed [XW-1:0] x, y, x_nx, y_nx, re_w, im_w;
  logic [15:0] z, z_nx, a;
  logic [4:0] i;
  logic zero, last;
  function automatic logic [15:0] atan_lut(input logic [4:0] k);
    case (k)
      5'd0:    atan_lut = 16'd8192;
      5'd1:    atan_lut = 16'd4836;
      5'd2:    atan_lut = 16'd2555;
      5'd3:    atan_lut = 16'd1297;
      5'd4:    atan_lut = 16'd651;
      5'd5:    atan_lut = 16'd326;
      5'd6:    atan_lut = 16'd163;
      5'd7:    atan_lut = 16'd81;
      5'd8:    atan_lut = 16'd41;
      5'd9:    atan_lut = 16'd20;
      5'd10:   atan_lut = 16'd10;
      5'd11:   atan_lut = 16'd5;
      5'd12:   atan_lut = 16'd3;
      5'd13:   atan_lut = 16'd1;
      5'd14:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign last      = i == 5'(ITER - 1);
  // widened before negation so -2^(DATA_W-1) survives the pre-rotation
  assign re_w = XW'(in_re);
  assign im_w = XW'(in_im);
  always_comb begin
    state_nx = (state == IDLE && in_valid) ? RUN :
               (state == RUN && last)      ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
    a    = atan_lut(i);
    x_nx = y[XW-1] ? x - (y >>> i) : x + (y >>> i);
    y_nx = y[XW-1] ? y + (x >>> i) : y - (x >>> i);
    z_nx = y[XW-1] ? z - a : z + a;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      i         <= '0;
      zero      <= 1'b0;
      out_phase <= '0;
      out_mag   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        x    <= in_re[DATA_W-1] ? -re_w : re_w;
        y    <= in_re[DATA_W-1] ? -im_w : im_w;
        z    <= in_re[DATA_W-1] ? 16'h8000 : 16'h0000;
        i    <= '0;
        zero <= in_re == '0 && in_im == '0;
      end
      if (state == RUN) begin
        x <= x_nx;
        y <= y_nx;
        z <= z_nx;
        i <= i + 5'd1;
        if (last) begin
          out_phase <= zero ? '0 : PHASE_W'((z_nx + 16'(1 << (15 - PHASE_W))) >> (16 - PHASE_W));
          out_mag   <= zero ? '0 : x_nx[DATA_W:0];
        end
      end
    end
  end
endmodule
